// File: rtl/register_file_pkg.sv
// Shared constants and helpers for the flip-flop register file.
package register_file_pkg;

    localparam int DEFAULT_WORD_WIDTH = 32;
    localparam int DEFAULT_LENGTH     = 128;

    // Address width for a given word count; never below one bit.
    function automatic int addr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/register_file_decoder.sv
// One-hot per-word write-enable decoder; out-of-range addresses enable nothing.
module register_file_decoder
    import register_file_pkg::*;
#(
    parameter int length = DEFAULT_LENGTH,
    parameter int AW     = addr_width(length)
) (
    input  logic              write,
    input  logic [AW-1:0]     write_address,
    output logic [length-1:0] word_we
);

    // Compare the zero-extended address against every word index.
    always_comb begin
        word_we = '0;
        for (int i = 0; i < length; i++) begin
            if (write && ({1'b0, write_address} == (AW+1)'(i))) begin
                word_we[i] = 1'b1;
            end else begin
                word_we[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/register_file.sv
// Flip-flop register file with registered read port.
// Define REGISTER_FILE_BYPASS_EN for write-through on same-address read/write.
module register_file
    import register_file_pkg::*;
#(
    parameter  int word_width = DEFAULT_WORD_WIDTH,
    parameter  int length     = DEFAULT_LENGTH,
    localparam int AW         = addr_width(length)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [AW-1:0]         write_address,
    input  logic [AW-1:0]         read_address,
    input  logic                  write,
    input  logic                  read,
    input  logic [word_width-1:0] in_data,
    output logic [word_width-1:0] out_data
);

    localparam logic [AW:0] LENGTH_W = (AW+1)'(length);

    logic [word_width-1:0] mem_q [length];
    logic [word_width-1:0] mem_d [length];
    logic [word_width-1:0] out_data_q;
    logic [word_width-1:0] out_data_d;
    logic [length-1:0]     word_we_s;
    logic                  read_in_range_s;

    register_file_decoder #(
        .length (length),
        .AW     (AW)
    ) u_decoder (
        .write         (write),
        .write_address (write_address),
        .word_we       (word_we_s)
    );

    // Next-state of the storage array from the decoded write enables.
    always_comb begin
        for (int i = 0; i < length; i++) begin
            if (word_we_s[i]) begin
                mem_d[i] = in_data;
            end else begin
                mem_d[i] = mem_q[i];
            end
        end
    end

    // Read mux: out-of-range reads return zero, disabled reads hold.
    always_comb begin
        out_data_d      = out_data_q;
        read_in_range_s = ({1'b0, read_address} < LENGTH_W);
        if (read) begin
            if (!read_in_range_s) begin
                out_data_d = '0;
`ifdef REGISTER_FILE_BYPASS_EN
            end else if (write && (read_address == write_address)) begin
                out_data_d = in_data;
`endif
            end else begin
                out_data_d = mem_q[read_address];
            end
        end else begin
            out_data_d = out_data_q;
        end
    end

    // State registers; reset clears every word and the read register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q      <= '{default: '0};
            out_data_q <= '0;
        end else begin
            mem_q      <= mem_d;
            out_data_q <= out_data_d;
        end
    end

    assign out_data = out_data_q;

endmodule

// File: tb/tb_register_file.sv
// Randomized and directed bench for register_file against an array-based reference model.
module tb_register_file;

    localparam int WW  = 32;
    localparam int LEN = 128;
    localparam int AW  = 7;

`ifdef REGISTER_FILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk;
    logic          reset_n;
    logic [AW-1:0] write_address;
    logic [AW-1:0] read_address;
    logic          write;
    logic          read;
    logic [WW-1:0] in_data;
    logic [WW-1:0] out_data;

    logic [WW-1:0] model_mem [LEN];
    logic [WW-1:0] exp_out;
    int            n_checks;
    int            n_errors;

    register_file #(
        .word_width (WW),
        .length     (LEN)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .write_address (write_address),
        .read_address  (read_address),
        .write         (write),
        .read          (read),
        .in_data       (in_data),
        .out_data      (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < LEN; i++) model_mem[i] = '0;
        exp_out = '0;
    endtask

    // Called at a negedge: drive inputs, let one rising edge pass, update model, check at next negedge.
    task automatic do_cycle(input string tag, input logic w, input int wa, input logic r,
                            input int ra, input logic [WW-1:0] din);
        write         = w;
        write_address = AW'(wa);
        read          = r;
        read_address  = AW'(ra);
        in_data       = din;
        @(posedge clk);
        if (r) begin
            if (ra >= LEN)                       exp_out = '0;
            else if (BYPASS && w && (wa == ra))  exp_out = din;
            else                                 exp_out = model_mem[ra];
        end
        if (w && (wa < LEN)) model_mem[wa] = din;
        @(negedge clk);
        check_val(tag, out_data, exp_out);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset_n       = 1'b0;
        write         = 1'b0;
        read          = 1'b0;
        write_address = '0;
        read_address  = '0;
        in_data       = '0;
        model_clear();
        #1;
        check_val("reset_async", out_data, 32'd0);
        repeat (3) @(negedge clk);
        check_val("reset_out", out_data, 32'd0);
        reset_n = 1'b1;

        for (int a = 0; a < LEN; a++) do_cycle("reset_word", 1'b0, 0, 1'b1, a, 32'd0);

        do_cycle("wr_rd_same", 1'b1, 8, 1'b1, 8, 32'd888888888);
        do_cycle("wr_then_rd", 1'b0, 0, 1'b1, 8, 32'd0);
        check_val("wr_then_rd_const", out_data, 32'd888888888);

        do_cycle("wr_disabled", 1'b0, 43, 1'b0, 0, 32'd66666);
        do_cycle("wr_disabled_rd", 1'b0, 0, 1'b1, 43, 32'd0);
        check_val("wr_disabled_const", out_data, 32'd0);

        do_cycle("rd_setup", 1'b0, 0, 1'b1, 8, 32'd0);
        for (int k = 0; k < 4; k++)
            do_cycle("rd_hold", 1'b1, 100 + k, 1'b0, 10 + k, $urandom);
        check_val("rd_hold_const", out_data, 32'd888888888);

        do_cycle("same_addr", 1'b1, 91, 1'b1, 91, 32'd99999);
        check_val("same_addr_const", out_data, BYPASS ? 32'd99999 : 32'd0);
        do_cycle("same_addr_next", 1'b0, 0, 1'b1, 91, 32'd0);
        check_val("same_addr_next_const", out_data, 32'd99999);

        do_cycle("pre_rst_wr", 1'b1, 57, 1'b1, 57, 32'd575757);
        write = 1'b1;
        write_address = AW'(57);
        read = 1'b1;
        read_address = AW'(57);
        in_data = 32'd123;
        reset_n = 1'b0;
        model_clear();
        #1;
        check_val("mid_rst_async", out_data, 32'd0);
        #199;
        check_val("mid_rst_hold", out_data, 32'd0);
        reset_n = 1'b1;
        do_cycle("post_rst_rd57", 1'b0, 0, 1'b1, 57, 32'd0);
        check_val("post_rst_rd57_const", out_data, 32'd0);
        do_cycle("post_rst_wr91", 1'b1, 91, 1'b0, 0, 32'd99999);
        do_cycle("post_rst_rd91", 1'b0, 0, 1'b1, 91, 32'd0);
        check_val("post_rst_rd91_const", out_data, 32'd99999);

        for (int k = 0; k < 600; k++) begin
            int wa;
            int ra;
            wa = $urandom_range(0, LEN - 1);
            ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, LEN - 1);
            do_cycle("random", 1'($urandom), wa, 1'($urandom), ra, $urandom);
        end

        for (int a = 0; a < LEN; a++) do_cycle("final_sweep", 1'b0, 0, 1'b1, a, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter word_width, default 32, data word width in bits (>=1).
REQ-002 Parameter length, default 128, number of words (>=2); AW = $clog2(length).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 write_address  input  AW  word index written when write=1.
REQ-006 read_address  input  AW  word index read when read=1.
REQ-007 write  input  1  write enable, sampled on the rising clk edge.
REQ-008 read  input  1  read enable, sampled on the rising clk edge.
REQ-009 in_data  input  word_width  write data.
REQ-010 out_data  output  word_width  registered read data.

Function
REQ-011 Storage SHALL be length words of word_width bits, implemented as flip-flops.
REQ-012 On a rising edge with write=1 and write_address<length, mem[write_address] SHALL take in_data.
REQ-013 On a rising edge with read=1, out_data SHALL take mem[read_address]; read latency is one cycle.
REQ-014 With read=0, out_data SHALL hold its previous value.
REQ-015 With write=0, no word SHALL change.
REQ-016 read and write SHALL operate independently and concurrently on any address pair in the same cycle.
REQ-017 Same-cycle read and write to the same address SHALL follow REQ-027 / REQ-028.
REQ-018 write_address>=length (non-power-of-two length only) SHALL be ignored.
REQ-019 read_address>=length SHALL load out_data with 0.
REQ-020 No handshake, stall or error output SHALL exist; every enabled access completes in its cycle.

Reset
REQ-021 reset_n=0 SHALL immediately clear every word and out_data to 0, independent of clk.
REQ-022 While reset_n=0, write and read SHALL have no effect.
REQ-023 Reset asserted mid-operation SHALL discard any access in progress; no partial update.
REQ-024 The first rising edge after reset_n rises SHALL process write/read normally.

Configuration
REQ-025 Macro REGISTER_FILE_BYPASS_EN SHALL select same-address read-during-write behaviour.
REQ-026 The macro SHALL affect only the case read=1, write=1, read_address==write_address, address<length.
REQ-027 Defined: out_data SHALL take in_data (write-through bypass).
REQ-028 Undefined: out_data SHALL take the old mem contents; the write still occurs.

Structure
REQ-029 Package register_file_pkg SHALL hold the default constants DEFAULT_WORD_WIDTH=32 and DEFAULT_LENGTH=128.
REQ-030 Sub-module register_file_decoder SHALL convert write_address plus write into a one-hot per-word write-enable vector of length bits.
REQ-031 The read mux and the bypass logic SHALL stay in the top module.

Verification
REQ-032 Reset: assert reset_n=0 -> out_data=0; all 128 words read back 0.
REQ-033 Write then read:
- write=1, read=1, write_address=8, in_data=888888888 in one cycle.
- Next cycle read_address=8 -> out_data=888888888 one cycle later.
REQ-034 Write disable: write=0, write_address=43, in_data=66666 -> mem[43] stays 0 on a later read.
REQ-035 Read disable: read=0 while other addresses change -> out_data holds its prior value.
REQ-036 Same-address access: read_address=write_address=91, in_data=99999, mem[91] previously 0:
- With REGISTER_FILE_BYPASS_EN: out_data=99999 in the same read cycle.
- Without it: out_data=0, then 99999 on the following read.
REQ-037 Reset mid-run:
- After writing 575757 to word 57, pulse reset_n low for 200 ns.
- Read 57 -> out_data=0.
- Write 99999 to 91, then read 91 -> 99999.
